// File: rtl/fetch_queue_stage_pkg.sv
// Shared types for the fetch stage: machine word, queue entry layout and fetch FSM states.
package fetch_queue_stage_pkg;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        lc3b_word instr;
        lc3b_word pc;
        lc3b_word pc_plus2;
        lc3b_word pred_pc;
        logic     pred_taken;
    } fetch_entry_t;

    function automatic lc3b_word pc_inc2(input lc3b_word pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory request/response and decode-side valid/ready bundle.
interface fetch_queue_stage_if #(
    parameter int LINE_BITS = 128
);
    import fetch_queue_stage_pkg::*;

    lc3b_word               imem_address;
    logic                   imem_read;
    logic [LINE_BITS-1:0]   imem_rdata;
    logic                   imem_resp;

    logic                   out_valid;
    logic                   out_ready;
    lc3b_word               out_instr;
    lc3b_word               out_pc;
    lc3b_word               out_pc_plus2;
    lc3b_word               out_pred_pc;
    logic                   out_pred_taken;

    modport master (
        output imem_address, imem_read,
        input  imem_rdata, imem_resp,
        output out_valid, out_instr, out_pc, out_pc_plus2, out_pred_pc, out_pred_taken,
        input  out_ready
    );

    modport slave (
        input  imem_address, imem_read,
        output imem_rdata, imem_resp,
        input  out_valid, out_instr, out_pc, out_pc_plus2, out_pred_pc, out_pred_taken,
        output out_ready
    );

endinterface

// File: rtl/fetch_queue_stage_btb_2bit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module btb_2bit
    import fetch_queue_stage_pkg::*;
#(
    parameter int ENTRIES = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  lc3b_word i_lookup_pc,
    output logic     o_pred_taken,
    output lc3b_word o_pred_pc,
    input  logic     i_upd,
    input  lc3b_word i_upd_pc,
    input  lc3b_word i_upd_target,
    input  logic     i_upd_taken
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 15 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [1:0]         r_ctr    [ENTRIES];
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    lc3b_word           r_target [ENTRIES];

    logic [IDX_W-1:0]   w_lidx, w_uidx;
    logic [TAG_W-1:0]   w_ltag, w_utag;
    logic               w_lhit, w_uhit;
    logic               w_unused_pc0;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign w_lidx = i_lookup_pc[IDX_W:1];
    assign w_ltag = i_lookup_pc[15:IDX_W+1];
    assign w_uidx = i_upd_pc[IDX_W:1];
    assign w_utag = i_upd_pc[15:IDX_W+1];
    assign w_unused_pc0 = i_lookup_pc[0] ^ i_upd_pc[0];

    // Lookup reads registered state, so a same-cycle update is not visible yet.
    assign w_lhit       = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
    assign w_uhit       = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign o_pred_taken = w_lhit && r_ctr[w_lidx][1];
    assign o_pred_pc    = o_pred_taken ? r_target[w_lidx] : pc_inc2(i_lookup_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                r_ctr[i] <= 2'b00;
        end else if (i_upd) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= sat_ctr(r_ctr[w_uidx], i_upd_taken);
            end else if (i_upd_taken) begin
                r_valid[w_uidx] <= 1'b1;
                r_ctr[w_uidx]   <= 2'b10;
            end
        end
    end

    // Taken updates either refresh a hit's target or allocate over a miss.
    always_ff @(posedge clk) begin
        if (i_upd && i_upd_taken) begin
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= i_upd_target;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch stage: flush-aware request FSM, BTB prediction and a small instruction queue toward decode.
module fetch_queue_stage
    import fetch_queue_stage_pkg::*;
#(
    parameter int          LINE_BITS   = 128,
    parameter int          DEPTH       = 4,
    parameter int          BTB_ENTRIES = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  lc3b_word           flush_pc,
    input  logic               bp_update,
    input  lc3b_word           bp_pc,
    input  lc3b_word           bp_target,
    input  logic               bp_taken,
    fetch_queue_stage_if.master bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WSEL_W = $clog2(LINE_BITS / 16);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    fetch_state_t     r_state, w_state_nxt;
    lc3b_word         r_pc, w_pc_nxt;
    lc3b_word         r_redirect_pc, w_redirect_nxt;
    fetch_entry_t     r_queue [DEPTH];
    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count, w_cnt_after;

    logic              w_pred_taken;
    lc3b_word          w_pred_pc;
    logic [WSEL_W-1:0] w_wsel;
    lc3b_word          w_instr;
    fetch_entry_t      w_entry, w_head;
    logic              w_out_valid, w_deq, w_enq, w_imem_read;

    btb_2bit #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .reset        (reset),
        .i_lookup_pc  (r_pc),
        .o_pred_taken (w_pred_taken),
        .o_pred_pc    (w_pred_pc),
        .i_upd        (bp_update),
        .i_upd_pc     (bp_pc),
        .i_upd_target (bp_target),
        .i_upd_taken  (bp_taken)
    );

    assign w_wsel  = r_pc[WSEL_W:1];
    assign w_instr = bus.imem_rdata[{w_wsel, 4'b0000} +: 16];
    assign w_entry = '{instr: w_instr, pc: r_pc, pc_plus2: pc_inc2(r_pc),
                       pred_pc: w_pred_pc, pred_taken: w_pred_taken};

    assign w_out_valid = (r_count != '0) && !flush;
    assign w_deq       = w_out_valid && bus.out_ready;
    assign w_cnt_after = r_count + CNT_W'(1) - CNT_W'(w_deq);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = r_redirect_pc;
        w_enq          = 1'b0;
        w_imem_read    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (flush) begin
                    w_pc_nxt    = flush_pc;
                    w_state_nxt = FETCH;
                end else if (r_count != FULL) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_imem_read = 1'b1;
                if (flush) begin
                    // With the line already here the redirect is immediate; otherwise
                    // the address must stay put until the stale line drains.
                    if (bus.imem_resp) begin
                        w_pc_nxt = flush_pc;
                    end else begin
                        w_redirect_nxt = flush_pc;
                        w_state_nxt    = DROP;
                    end
                end else if (bus.imem_resp) begin
                    w_enq       = 1'b1;
                    w_pc_nxt    = w_pred_pc;
                    w_state_nxt = (w_cnt_after != FULL) ? FETCH : IDLE;
                end
            end
            DROP: begin
                w_imem_read = 1'b1;
                if (flush)
                    w_redirect_nxt = flush_pc;
                if (bus.imem_resp) begin
                    w_pc_nxt    = flush ? flush_pc : r_redirect_pc;
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_redirect_pc <= RESET_PC;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_redirect_pc <= w_redirect_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_tail <= r_tail + PTR_W'(1);
            if (w_deq)
                r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq)
            r_queue[r_tail] <= w_entry;
    end

    assign w_head = r_queue[r_head];

    assign bus.imem_address   = r_pc;
    assign bus.imem_read      = w_imem_read;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_instr      = w_head.instr;
    assign bus.out_pc         = w_head.pc;
    assign bus.out_pc_plus2   = w_head.pc_plus2;
    assign bus.out_pred_pc    = w_head.pred_pc;
    assign bus.out_pred_taken = w_head.pred_taken;

endmodule
